// File: rtl/adc_avg_pkg.sv
// adc_avg_pkg: shared width, FSM state encoding and default alarm thresholds.
package adc_avg_pkg;
    localparam int ADC_W = 12;
    localparam logic [ADC_W-1:0] ALARM_HI_DEF = 12'd3000;
    localparam logic [ADC_W-1:0] ALARM_LO_DEF = 12'd2800;
    typedef enum logic [1:0] {IDLE, CAPTURE, ACCUM, PUBLISH} state_t;
endpackage

// File: rtl/adc_chan_avg.sv
// adc_chan_avg: per-channel sample register, boxcar accumulator with truncating average, and peak hold.
module adc_chan_avg
    import adc_avg_pkg::*;
#(
    parameter int AVG_LOG2  = 4,
    parameter int PEAK_HOLD = 256
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             capture,
    input  logic             accum,
    input  logic             publish,
    input  logic [ADC_W-1:0] din,
    output logic [ADC_W-1:0] avg_next,
    output logic [ADC_W-1:0] peak
);
    localparam int ACC_W = ADC_W + AVG_LOG2;
    localparam int HOLD_W = (PEAK_HOLD > 1) ? $clog2(PEAK_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(PEAK_HOLD - 1);
    logic [ADC_W-1:0]  s;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  sum;
    logic [HOLD_W-1:0] hold;
    // sum already includes the final sample, so the average is ready in the publishing ACCUM cycle
    assign sum      = acc + ACC_W'(s);
    assign avg_next = ADC_W'(sum >> AVG_LOG2);
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s    <= '0;
            acc  <= '0;
            peak <= '0;
            hold <= '0;
        end else begin
            if (capture) s <= din;
            if (accum) begin
                acc <= publish ? '0 : sum;
                if (s > peak || hold == HOLD_LAST) begin
                    peak <= s;
                    hold <= '0;
                end else begin
                    hold <= hold + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/adc_avg_peak.sv
// adc_avg_peak: sample tick, capture/accumulate/publish FSM, per-channel averaging and channel-1 alarm.
// Define ALARM_LATCH_EN for a sticky alarm that only alarm_clr releases.
module adc_avg_peak
    import adc_avg_pkg::*;
#(
    parameter int               SAMPLE_DIV = 1024,
    parameter int               AVG_LOG2   = 4,
    parameter int               PEAK_HOLD  = 256,
    parameter logic [ADC_W-1:0] ALARM_HI   = ALARM_HI_DEF,
    parameter logic [ADC_W-1:0] ALARM_LO   = ALARM_LO_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [ADC_W-1:0] AIN1,
    input  logic [ADC_W-1:0] AIN2,
`ifdef ALARM_LATCH_EN
    input  logic             alarm_clr,
`endif
    output logic [ADC_W-1:0] avg1,
    output logic [ADC_W-1:0] avg2,
    output logic             avg_valid,
    output logic [ADC_W-1:0] peak1,
    output logic [ADC_W-1:0] peak2,
    output logic             alarm
);
    localparam int TICK_W = $clog2(SAMPLE_DIV);
    localparam int SMP_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);
    state_t            state;
    logic [TICK_W-1:0] tick_cnt;
    logic [SMP_W-1:0]  smp_cnt;
    logic              tick;
    logic              capture;
    logic              accum;
    logic              publish;
    logic              alarm_d;
    logic [ADC_W-1:0]  avg1_next;
    logic [ADC_W-1:0]  avg2_next;
    assign tick    = tick_cnt == TICK_W'(SAMPLE_DIV - 1);
    assign capture = state == CAPTURE;
    assign accum   = state == ACCUM;
    assign publish = accum && smp_cnt == SMP_LAST;
`ifdef ALARM_LATCH_EN
    assign alarm_d = (publish && avg1_next >= ALARM_HI) || (alarm && !alarm_clr);
`else
    assign alarm_d = publish ? (avg1_next >= ALARM_HI || (alarm && avg1_next >= ALARM_LO)) : alarm;
`endif
    adc_chan_avg #(.AVG_LOG2(AVG_LOG2), .PEAK_HOLD(PEAK_HOLD)) u_ch1 (
        .clock(clock), .reset_n(reset_n), .capture(capture), .accum(accum), .publish(publish),
        .din(AIN1), .avg_next(avg1_next), .peak(peak1)
    );
    adc_chan_avg #(.AVG_LOG2(AVG_LOG2), .PEAK_HOLD(PEAK_HOLD)) u_ch2 (
        .clock(clock), .reset_n(reset_n), .capture(capture), .accum(accum), .publish(publish),
        .din(AIN2), .avg_next(avg2_next), .peak(peak2)
    );
    // The final ACCUM cycle writes the averages, so avg_valid is high during PUBLISH.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            smp_cnt   <= '0;
            avg1      <= '0;
            avg2      <= '0;
            avg_valid <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            state     <= (state == IDLE) ? (tick ? CAPTURE : IDLE) : capture ? ACCUM : publish ? PUBLISH : IDLE;
            tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
            if (accum) smp_cnt <= publish ? '0 : smp_cnt + 1'b1;
            if (publish) begin
                avg1 <= avg1_next;
                avg2 <= avg2_next;
            end
            avg_valid <= publish;
            alarm     <= alarm_d;
        end
    end
endmodule

// File: tb/tb_adc_avg_peak.sv
// tb_adc_avg_peak: directed checks of averaging, peak hold, alarm and reset on a fast-tick instance,
// plus first-publish latency of a default-parameter instance.
module tb_adc_avg_peak;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        rst0_n = 1'b0;
    logic        alarm_clr = 1'b0;
    logic [11:0] ain1 = '0;
    logic [11:0] ain2 = '0;
    logic [11:0] avg1, avg2, peak1, peak2;
    logic        avg_valid, alarm;
    logic [11:0] avg1_0, avg2_0, peak1_0, peak2_0;
    logic        avg_valid_0, alarm_0;
    logic        v_seen = 1'b0;
    logic        a_cap = 1'b0;
    int          errors = 0;
    int          checks = 0;
    int          early = 0;
    int          n0 = 0;
    int          first0 = 0;

    always #5 clock = ~clock;

    adc_avg_peak #(.SAMPLE_DIV(8)) dut (
        .clock(clock), .reset_n(reset_n), .AIN1(ain1), .AIN2(ain2),
`ifdef ALARM_LATCH_EN
        .alarm_clr(alarm_clr),
`endif
        .avg1(avg1), .avg2(avg2), .avg_valid(avg_valid), .peak1(peak1), .peak2(peak2), .alarm(alarm)
    );

    adc_avg_peak dut0 (
        .clock(clock), .reset_n(rst0_n), .AIN1(12'd1000), .AIN2(12'd50),
`ifdef ALARM_LATCH_EN
        .alarm_clr(1'b0),
`endif
        .avg1(avg1_0), .avg2(avg2_0), .avg_valid(avg_valid_0), .peak1(peak1_0), .peak2(peak2_0), .alarm(alarm_0)
    );

    // Edge count since dut0 reset release; first0 records the edge after which avg_valid is first seen.
    always @(posedge clock) if (rst0_n) n0 <= n0 + 1;
    always @(negedge clock) if (avg_valid_0 && first0 == 0) first0 <= n0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Entered 1 time unit after a tick edge; returns 1 time unit after the next tick edge.
    task automatic sample(input logic [11:0] v1, input logic [11:0] v2, input int clr);
        ain1 = v1;
        ain2 = v2;
        alarm_clr = (clr == 1);
        @(posedge clock);
        #1;
        a_cap = alarm;
        alarm_clr = (clr == 2);
        @(posedge clock);
        #1;
        alarm_clr = 1'b0;
        v_seen = avg_valid;
        repeat (6) @(posedge clock);
        #1;
    endtask

    task automatic batch(input logic [11:0] v1, input logic [11:0] v2);
        early = 0;
        for (int i = 0; i < 15; i++) begin
            sample(v1, v2, 0);
            early += int'(v_seen);
        end
        sample(v1, v2, 0);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("rst_avg1", avg1, 0);
        chk("rst_avg2", avg2, 0);
        chk("rst_peak1", peak1, 0);
        chk("rst_peak2", peak2, 0);
        chk("rst_valid", avg_valid, 0);
        chk("rst_alarm", alarm, 0);
        reset_n = 1'b1;
        rst0_n = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        batch(12'd1000, 12'd50);
        chk("const_early", early, 0);
        chk("const_valid", v_seen, 1);
        chk("const_avg1", avg1, 1000);
        chk("const_avg2", avg2, 50);
        chk("const_alarm", alarm, 0);
        chk("const_peak1", peak1, 1000);
        chk("const_peak2", peak2, 50);
        early = 0;
        for (int k = 0; k < 16; k++) begin
            sample(12'(k), 12'd50, 0);
            if (k < 15) early += int'(v_seen);
        end
        chk("ramp_early", early, 0);
        chk("ramp_valid", v_seen, 1);
        chk("ramp_avg1", avg1, 7);
        batch(12'd3000, 12'd50);
        chk("hyst_set_valid", v_seen, 1);
        chk("hyst_set_avg1", avg1, 3000);
        chk("hyst_set", alarm, 1);
        chk("hyst_peak1", peak1, 3000);
        batch(12'd2900, 12'd50);
        chk("hyst_hold", alarm, 1);
        batch(12'd2799, 12'd50);
        chk("hyst_low_avg1", avg1, 2799);
`ifdef ALARM_LATCH_EN
        chk("latch_hold_lo", alarm, 1);
        batch(12'd0, 12'd50);
        chk("latch_hold_zero", alarm, 1);
        sample(12'd0, 12'd50, 1);
        chk("latch_clr", a_cap, 0);
        repeat (15) sample(12'd0, 12'd50, 0);
        chk("latch_clr_pub", alarm, 0);
        repeat (15) sample(12'd3000, 12'd50, 0);
        sample(12'd3000, 12'd50, 2);
        chk("latch_set_valid", v_seen, 1);
        chk("latch_set_wins", alarm, 1);
`else
        chk("hyst_clear", alarm, 0);
`endif
        repeat (8) sample(12'd4000, 12'd4000, 0);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        chk("mid_rst_avg1", avg1, 0);
        chk("mid_rst_avg2", avg2, 0);
        chk("mid_rst_peak1", peak1, 0);
        chk("mid_rst_peak2", peak2, 0);
        chk("mid_rst_valid", avg_valid, 0);
        chk("mid_rst_alarm", alarm, 0);
        reset_n = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        batch(12'd200, 12'd300);
        chk("post_rst_early", early, 0);
        chk("post_rst_valid", v_seen, 1);
        chk("post_rst_avg1", avg1, 200);
        chk("post_rst_avg2", avg2, 300);
        chk("post_rst_peak1", peak1, 200);
        sample(12'd200, 12'd4095, 0);
        chk("spike_peak2", peak2, 4095);
        repeat (255) sample(12'd200, 12'd100, 0);
        chk("spike_held", peak2, 4095);
        sample(12'd200, 12'd100, 0);
        chk("spike_release", peak2, 100);
        for (int i = 0; i < 30000 && first0 == 0; i++) @(posedge clock);
        #1;
        chk("dflt_latency", first0, 16 * 1024 + 2);
        chk("dflt_avg1", avg1_0, 1000);
        chk("dflt_avg2", avg2_0, 50);
        chk("dflt_alarm", alarm_0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
